ahb_lite_ram_ctrl: RTL and testbench
====================================

// Module: ahb_lite_ram_ctrl
//
// PURPOSE
// AHB-Lite slave front-end that drives four byte-lane simple dual-port RAMs
// (sync write, sync read, 1-cycle read latency, read-old-on-collision).
// Converts bus address/data phases into per-lane write enables and read
// addresses. Returns zero-wait-state responses, forwards just-written bytes on
// back-to-back write->read, and returns a two-cycle ERROR on misaligned access.
//
// PARAMETERS
// ADDR_WIDTH  6  word-address width of each lane RAM; depth = 2**ADDR_WIDTH words
//
// PORTS
// HCLK            in   1           system clock, all state on rising edge
// HRESETn         in   1           asynchronous active-low reset
// HSEL            in   1           slave select
// HADDR           in   32          byte address; word index = HADDR[ADDR_WIDTH+1:2]
// HTRANS          in   2           IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
// HWRITE          in   1           1 = write transfer
// HSIZE           in   3           0 byte, 1 halfword, 2 word; >2 illegal
// HWDATA          in   32          write data, valid in write data phase
// HREADY          in   1           bus-level ready (from interconnect mux)
// HRDATA          out  32          read data, valid in read data phase
// HREADYOUT       out  1           slave ready
// HRESP           out  1           0 OKAY, 1 ERROR
// ram_read_addr   out  ADDR_WIDTH  read word address, shared by all lanes
// ram_write_addr  out  ADDR_WIDTH  write word address, shared by all lanes
// ram_wdata       out  32          write data; lane n = bits [8n+7:8n]
// ram_we          out  4           per-lane write enable, lane n -> bit n
// ram_rdata       in   32          lane q outputs concatenated {b3,b2,b1,b0}
//
// BEHAVIOUR
// - Transfer accepted at an edge when HSEL & HREADY & HTRANS[1]. On accept:
//   register write flag, word index, byte mask, legality.
// - Byte mask: HSIZE=0 -> 1<<HADDR[1:0]. HSIZE=1 -> 0011 (HADDR[1]=0) or
//   1100 (HADDR[1]=1). HSIZE=2 -> 1111.
// - Illegal: HSIZE>2, halfword with HADDR[0]=1, word with HADDR[1:0]!=0.
// - Upper address bits ignored; word index wraps modulo 2**ADDR_WIDTH.
// - FSM: IDLE, DATA, ERR1, ERR2.
//   IDLE->DATA on legal accept. IDLE->ERR1 on illegal accept.
//   DATA->DATA on legal accept, ->ERR1 on illegal, ->IDLE otherwise.
//   ERR1->ERR2 always. ERR2 behaves as IDLE for the next accept.
// - Outputs per state:
//   ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1.
//   Otherwise HREADYOUT=1, HRESP=0.
// - Illegal transfers never assert ram_we; their read data is don't-care.
// - Write: in DATA with registered write flag, combinationally drive
//   ram_we=mask, ram_write_addr=registered index, ram_wdata=HWDATA. The RAM
//   commits at the end of the data phase. ram_we=0 in every other state.
// - Read: ram_read_addr = HADDR word index, combinational in address phase.
//   HRDATA = ram_rdata in the following data phase; latency 1, no wait states.
// - Hazard: if a read is accepted while a write data phase to the same word
//   is active, the RAM returns old data. At that edge, capture HWDATA and
//   ram_we into a forward register. In the read data phase, lanes whose
//   forward bit is set take forwarded bytes; other lanes take ram_rdata.
//   Forward bits clear after that data phase.
// - BUSY/IDLE HTRANS, or HSEL=0: no accept. A write data phase in progress
//   still completes.
// - Reset (async, HRESETn=0): FSM=IDLE, HREADYOUT=1, HRESP=0, ram_we=0,
//   registered flags/mask/forward cleared.
// - Reset mid write data phase drops that write. HRDATA during reset is
//   don't-care.
//
// TESTING
// 1. Word write 0xDEADBEEF @0x10, then read @0x10 one cycle later (pipelined)
//    -> ram_we=1111 at addr 4; HRDATA=0xDEADBEEF via forward, HREADYOUT=1.
// 2. Word 0x11223344 @0x20; byte write 0xAA @0x22 (HWDATA=0x00AA0000);
//    idle; read word @0x20 -> ram_we=0100; HRDATA=0x11AA3344.
// 3. Halfword read @0x03 -> HREADYOUT 0 then 1, HRESP 1 for two cycles;
//    no ram_we pulse. Next NONSEQ is accepted normally.
// 4. Write @0x100 with ADDR_WIDTH=6 -> ram_write_addr=0 (wrap). Readback
//    @0x0 returns the same data.
// 5. Assert HRESETn=0 during a write data phase -> ram_we=0 immediately,
//    target word unchanged on later read. HREADYOUT=1, HRESP=0 after reset.
// 6. HSEL=1 with HTRANS=BUSY/IDLE for 10 cycles -> no ram_we, HRESP=0,
//    HREADYOUT=1 throughout.

Source files
------------

// File: rtl/ahb_lite_ram_ctrl_if.sv
// rtl/ahb_lite_ram_ctrl_if.sv - AHB-Lite bus signals between master/interconnect and the RAM controller slave
interface ahb_lite_ram_ctrl_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_lite_ram_ctrl.sv
// rtl/ahb_lite_ram_ctrl.sv - AHB-Lite slave front-end for four byte-lane dual-port RAMs
module ahb_lite_ram_ctrl #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ahb_lite_ram_ctrl_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            mask_q;
    logic [3:0]            fwd_mask_q;
    logic [31:0]           fwd_data_q;

    logic                  accept;
    logic                  take;
    logic                  illegal;
    logic [3:0]            mask;
    logic [ADDR_WIDTH-1:0] addr_idx;
    logic                  wr_active;
    logic                  hazard;

    // Upper address bits and HTRANS[0] carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.haddr[31:ADDR_WIDTH+2], bus.htrans[0]};

    assign accept   = bus.hsel & bus.hready & bus.htrans[1];
    // ERR1 holds the bus stalled, so nothing can be taken there.
    assign take     = accept && (state_q != ST_ERR1);
    assign addr_idx = bus.haddr[ADDR_WIDTH+1:2];

    // Byte-lane mask and alignment legality of the address-phase transfer.
    always_comb begin
        mask    = 4'b0000;
        illegal = 1'b0;
        case (bus.hsize)
            3'd0: begin
                mask    = 4'b0001 << bus.haddr[1:0];
                illegal = 1'b0;
            end
            3'd1: begin
                mask    = bus.haddr[1] ? 4'b1100 : 4'b0011;
                illegal = bus.haddr[0];
            end
            3'd2: begin
                mask    = 4'b1111;
                illegal = (bus.haddr[1:0] != 2'b00);
            end
            default: begin
                mask    = 4'b0000;
                illegal = 1'b1;
            end
        endcase
    end

    // A read landing on the word whose write is committing this edge sees old RAM data.
    assign wr_active = (state_q == ST_DATA) && wr_q;
    assign hazard    = take && !illegal && !bus.hwrite && wr_active && (addr_idx == idx_q);

    // Next-state selection for the transfer pipeline.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state_q)
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (take) begin
                    state_nxt = illegal ? ST_ERR1 : ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // FSM, registered bus response and captured address-phase attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            mask_q      <= 4'b0000;
        end else begin
            state_q     <= state_nxt;
            hreadyout_q <= (state_nxt != ST_ERR1);
            hresp_q     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
            if (take) begin
                wr_q   <= bus.hwrite & ~illegal;
                idx_q  <= addr_idx;
                mask_q <= illegal ? 4'b0000 : mask;
            end else begin
                wr_q   <= 1'b0;
            end
        end
    end

    // Forwarding register: live for exactly the one read data phase after a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_mask_q <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            fwd_mask_q <= hazard ? ram_we : 4'b0000;
            if (hazard) begin
                fwd_data_q <= bus.hwdata;
            end
        end
    end

    assign ram_we         = wr_active ? mask_q : 4'b0000;
    assign ram_write_addr = idx_q;
    assign ram_wdata      = bus.hwdata;
    assign ram_read_addr  = addr_idx;

    // Per-lane merge of forwarded bytes over the RAM output.
    always_comb begin
        bus.hrdata = ram_rdata;
        for (int n = 0; n < 4; n++) begin
            if (fwd_mask_q[n]) begin
                bus.hrdata[8*n +: 8] = fwd_data_q[8*n +: 8];
            end
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_ram_ctrl.sv
// tb/tb_ahb_lite_ram_ctrl.sv - directed self-checking bench for ahb_lite_ram_ctrl
module tb_ahb_lite_ram_ctrl;

    localparam int          AW     = 6;
    localparam logic [1:0]  T_IDLE = 2'b00;
    localparam logic [1:0]  T_BUSY = 2'b01;
    localparam logic [1:0]  T_NSEQ = 2'b10;
    localparam logic [31:0] FILL   = 32'h5555_5555;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ram_read_addr;
    logic [AW-1:0] ram_write_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;

    int checks = 0;
    int errors = 0;

    ahb_lite_ram_ctrl_if bus();

    ahb_lite_ram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .ram_read_addr  (ram_read_addr),
        .ram_write_addr (ram_write_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_rdata      (ram_rdata)
    );

    // single-slave interconnect: bus ready follows slave ready
    assign bus.hready = bus.hreadyout;

    always #5 clk = ~clk;

    // byte-lane RAM model: sync write, sync read, old data on collision
    logic [31:0] mem [0:(1<<AW)-1];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= FILL;
            mem_init_done <= 1'b1;
        end else begin
            for (int n = 0; n < 4; n++)
                if (ram_we[n]) mem[ram_write_addr][8*n +: 8] <= ram_wdata[8*n +: 8];
        end
        ram_rdata <= mem[ram_read_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr);
        bus.hsel   = sel;
        bus.htrans = trans;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.haddr  = addr;
    endtask

    task automatic go_idle();
        drive(1'b0, T_IDLE, 1'b0, 3'd2, 32'h0);
    endtask

    task automatic test_reset();
        go_idle();
        bus.hwdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %b exp 1", bus.hreadyout); end
        checks++; if (bus.hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp got %b exp 0", bus.hresp); end
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL rst_we got %b exp 0000", ram_we); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_forward();
        cyc(); drive(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h10);
        cyc(); bus.hwdata = 32'hDEAD_BEEF; drive(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h10); #1;
        checks++; if (ram_we !== 4'b1111) begin errors++; $display("FAIL fwd_we got %b exp 1111", ram_we); end
        checks++; if (ram_write_addr !== 6'd4) begin errors++; $display("FAIL fwd_waddr got %0d exp 4", ram_write_addr); end
        checks++; if (ram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_wdata got %h exp deadbeef", ram_wdata); end
        checks++; if (ram_read_addr !== 6'd4) begin errors++; $display("FAIL fwd_raddr got %0d exp 4", ram_read_addr); end
        cyc(); go_idle(); #1;
        checks++; if (bus.hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_hrdata got %h exp deadbeef", bus.hrdata); end
        checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL fwd_hreadyout got %b exp 1", bus.hreadyout); end
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL fwd_we_after got %b exp 0000", ram_we); end
    endtask

    task automatic test_byte_merge();
        cyc(); drive(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h20);
        cyc(); bus.hwdata = 32'h1122_3344; drive(1'b1, T_NSEQ, 1'b1, 3'd0, 32'h22);
        cyc(); bus.hwdata = 32'h00AA_0000; go_idle(); #1;
        checks++; if (ram_we !== 4'b0100) begin errors++; $display("FAIL byte_we got %b exp 0100", ram_we); end
        checks++; if (ram_write_addr !== 6'd8) begin errors++; $display("FAIL byte_waddr got %0d exp 8", ram_write_addr); end
        cyc();
        cyc(); drive(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20);
        cyc(); go_idle(); #1;
        checks++; if (bus.hrdata !== 32'h11AA_3344) begin errors++; $display("FAIL byte_hrdata got %h exp 11aa3344", bus.hrdata); end
    endtask

    task automatic test_masks();
        logic [2:0] sz  [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
        logic [1:0] lo  [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0};
        logic [3:0] exp [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            cyc(); drive(1'b1, T_NSEQ, 1'b1, sz[i], {28'h000_0005, 2'b00, lo[i]});
            cyc(); bus.hwdata = 32'h0; go_idle(); #1;
            checks++; if (ram_we !== exp[i]) begin errors++; $display("FAIL mask_%0d got %b exp %b", i, ram_we, exp[i]); end
        end
    endtask

    task automatic test_error();
        cyc(); drive(1'b1, T_NSEQ, 1'b0, 3'd1, 32'h03);
        cyc(); go_idle(); #1;
        checks++; if (bus.hreadyout !== 1'b0) begin errors++; $display("FAIL err1_hreadyout got %b exp 0", bus.hreadyout); end
        checks++; if (bus.hresp !== 1'b1) begin errors++; $display("FAIL err1_hresp got %b exp 1", bus.hresp); end
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL err1_we got %b exp 0000", ram_we); end
        cyc();
        checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL err2_hreadyout got %b exp 1", bus.hreadyout); end
        checks++; if (bus.hresp !== 1'b1) begin errors++; $display("FAIL err2_hresp got %b exp 1", bus.hresp); end
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL err2_we got %b exp 0000", ram_we); end
        drive(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h30);
        cyc(); bus.hwdata = 32'hCAFE_F00D; go_idle(); #1;
        checks++; if (bus.hresp !== 1'b0) begin errors++; $display("FAIL post_err_hresp got %b exp 0", bus.hresp); end
        checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL post_err_hreadyout got %b exp 1", bus.hreadyout); end
        checks++; if (ram_we !== 4'b1111) begin errors++; $display("FAIL post_err_we got %b exp 1111", ram_we); end
        checks++; if (ram_write_addr !== 6'd12) begin errors++; $display("FAIL post_err_waddr got %0d exp 12", ram_write_addr); end
    endtask

    task automatic test_wrap();
        cyc(); drive(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h100);
        cyc(); bus.hwdata = 32'h0BAD_F00D; go_idle(); #1;
        checks++; if (ram_write_addr !== 6'd0) begin errors++; $display("FAIL wrap_waddr got %0d exp 0", ram_write_addr); end
        checks++; if (ram_we !== 4'b1111) begin errors++; $display("FAIL wrap_we got %b exp 1111", ram_we); end
        cyc();
        cyc(); drive(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h0);
        cyc(); go_idle(); #1;
        checks++; if (bus.hrdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL wrap_hrdata got %h exp 0badf00d", bus.hrdata); end
    endtask

    task automatic test_reset_mid_write();
        cyc(); drive(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h40);
        cyc(); bus.hwdata = 32'h1234_5678; go_idle(); #1;
        checks++; if (ram_we !== 4'b1111) begin errors++; $display("FAIL rmw_we_pre got %b exp 1111", ram_we); end
        rst_n = 1'b0; #1;
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL rmw_we_rst got %b exp 0000", ram_we); end
        checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL rmw_hreadyout got %b exp 1", bus.hreadyout); end
        checks++; if (bus.hresp !== 1'b0) begin errors++; $display("FAIL rmw_hresp got %b exp 0", bus.hresp); end
        cyc();
        cyc(); rst_n = 1'b1;
        cyc(); drive(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h40);
        cyc(); go_idle(); #1;
        checks++; if (bus.hrdata !== FILL) begin errors++; $display("FAIL rmw_hrdata got %h exp %h", bus.hrdata, FILL); end
    endtask

    task automatic test_back_to_back();
        cyc(); drive(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h60);
        cyc(); bus.hwdata = 32'h7777_7777; drive(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h6A);
        cyc(); bus.hwdata = 32'hBEEF_0000; drive(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h68); #1;
        checks++; if (ram_we !== 4'b1100) begin errors++; $display("FAIL b2b_hw_we got %b exp 1100", ram_we); end
        cyc(); drive(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h64); #1;
        checks++; if (bus.hrdata !== 32'hBEEF_5555) begin errors++; $display("FAIL b2b_part_fwd got %h exp beef5555", bus.hrdata); end
        cyc(); go_idle(); #1;
        checks++; if (bus.hrdata !== FILL) begin errors++; $display("FAIL b2b_other_word got %h exp %h", bus.hrdata, FILL); end
    endtask

    task automatic test_no_transfer();
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL idle_we_%0d got %b exp 0000", i, ram_we); end
            checks++; if (bus.hresp !== 1'b0) begin errors++; $display("FAIL idle_hresp_%0d got %b exp 0", i, bus.hresp); end
            checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL idle_hreadyout_%0d got %b exp 1", i, bus.hreadyout); end
            drive(1'b1, i[0] ? T_BUSY : T_IDLE, 1'b1, 3'd2, 32'(i * 4));
            bus.hwdata = 32'hFFFF_FFFF;
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL nosel_we_%0d got %b exp 0000", i, ram_we); end
            drive(1'b0, T_NSEQ, 1'b1, 3'd2, 32'(i * 4));
        end
        cyc(); go_idle(); #1;
        checks++; if (ram_we !== 4'b0000) begin errors++; $display("FAIL nosel_we_last got %b exp 0000", ram_we); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_byte_merge();
        test_masks();
        test_error();
        test_wrap();
        test_reset_mid_write();
        test_back_to_back();
        test_no_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
